// File: rtl/prbs_multilevel_edge_shaper_if.sv
// Signal bundle between the LFSR/configuration side and the multilevel edge shaper.
interface prbs_multilevel_edge_shaper_if #(
    parameter int DATA_W = 16,
    parameter int TIME_W = 8
);
    logic                     prbs_bit_out;
    logic                     lfsr_clk_enable;
    logic [TIME_W-1:0]        rise_time_cfg;
    logic [TIME_W-1:0]        fall_time_cfg;
    logic signed [DATA_W-1:0] level_high;
    logic signed [DATA_W-1:0] level_low;
    logic [1:0]               filter_strength;
    logic signed [DATA_W-1:0] shaped_prbs_data;
    logic [1:0]               edge_state_dbg;
    logic [TIME_W-1:0]        edge_counter_dbg;
    logic                     edge_done;

    modport master (
        output prbs_bit_out, lfsr_clk_enable, rise_time_cfg, fall_time_cfg,
               level_high, level_low, filter_strength,
        input  shaped_prbs_data, edge_state_dbg, edge_counter_dbg, edge_done
    );

    modport slave (
        input  prbs_bit_out, lfsr_clk_enable, rise_time_cfg, fall_time_cfg,
               level_high, level_low, filter_strength,
        output shaped_prbs_data, edge_state_dbg, edge_counter_dbg, edge_done
    );
endinterface

// File: rtl/prbs_multilevel_edge_shaper.sv
// PRBS bit stream to signed DAC samples: exact-step ramps between programmable levels,
// sequential divider for the step size, Bresenham remainder spreading, one-pole IIR output.
module prbs_multilevel_edge_shaper #(
    parameter int DATA_W   = 16,
    parameter int TIME_W   = 8,
    parameter int FILT_MAX = 3
) (
    input  logic                         dac_clk,
    input  logic                         reset,
    prbs_multilevel_edge_shaper_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CALC      = 2'd1,
        RAMP      = 2'd2,
        IDLE_HIGH = 2'd3
    } state_t;

    function automatic logic [1:0] clamp_shift(input logic [1:0] k);
        if (int'(k) > FILT_MAX) return 2'(FILT_MAX);
        return k;
    endfunction

    // One restoring iteration: {rem, quo} shifts left and the quotient bit enters at the LSB.
    function automatic logic [TIME_W+DATA_W:0] div_iter(input logic [TIME_W-1:0] rem,
                                                        input logic [DATA_W:0]   quo,
                                                        input logic [TIME_W-1:0] n);
        logic [TIME_W:0] trial;
        logic            ge;
        trial = {rem, quo[DATA_W]};
        ge    = (trial >= {1'b0, n});
        if (ge) trial = trial - {1'b0, n};
        return {trial[TIME_W-1:0], quo[DATA_W-1:0], ge};
    endfunction

    function automatic logic signed [DATA_W-1:0] ramp_step(input logic signed [DATA_W-1:0] cur,
                                                           input logic [DATA_W:0]          step,
                                                           input logic                     neg);
        logic signed [DATA_W+1:0] acc;
        acc = {{2{cur[DATA_W-1]}}, cur};
        if (neg) acc = acc - signed'({1'b0, step});
        else     acc = acc + signed'({1'b0, step});
        return acc[DATA_W-1:0];
    endfunction

    // y + ((x - y) >>> k) always lies between y and x, so truncation back is lossless.
    function automatic logic signed [DATA_W-1:0] iir_step(input logic signed [DATA_W-1:0] y,
                                                          input logic signed [DATA_W-1:0] x,
                                                          input logic [1:0]               k);
        logic signed [DATA_W:0] acc;
        acc = signed'({x[DATA_W-1], x}) - signed'({y[DATA_W-1], y});
        acc = acc >>> k;
        acc = acc + signed'({y[DATA_W-1], y});
        return acc[DATA_W-1:0];
    endfunction

    state_t                   state, state_nxt;
    logic                     cur_bit, samp, neg, big, done_nxt, done_q;
    logic signed [DATA_W-1:0] ramp_p0, filt_p1, tgt_new;
    logic signed [DATA_W:0]   diff_new;
    logic [DATA_W:0]          mag_new, quo, step;
    logic [TIME_W-1:0]        n_new, n_len, rem, edge_cnt;
    logic [TIME_W:0]          err, esum;
    logic [CNT_W-1:0]         div_cnt;
    logic [TIME_W+DATA_W:0]   div_nxt;

    always_comb begin
        samp    = bus.lfsr_clk_enable && (bus.prbs_bit_out != cur_bit);
        tgt_new = bus.prbs_bit_out ? bus.level_high : bus.level_low;
        n_new   = bus.prbs_bit_out ? bus.rise_time_cfg : bus.fall_time_cfg;
        if (n_new == '0) n_new = TIME_W'(1);
        diff_new = signed'({tgt_new[DATA_W-1], tgt_new}) - signed'({ramp_p0[DATA_W-1], ramp_p0});
        mag_new  = diff_new[DATA_W] ? unsigned'(-diff_new) : unsigned'(diff_new);
        div_nxt  = div_iter(rem, quo, n_len);
        esum     = err + {1'b0, rem};
        big      = (esum >= {1'b0, n_len});
        step     = quo + {{DATA_W{1'b0}}, big};
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (samp) begin
            state_nxt = CALC;
        end else begin
            case (state)
                CALC: if (div_cnt == DIV_LAST) state_nxt = RAMP;
                RAMP: if (edge_cnt == TIME_W'(1)) begin
                    state_nxt = cur_bit ? IDLE_HIGH : IDLE_LOW;
                    done_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state  <= IDLE_LOW;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // Stage p0: edge capture, divider iterations and ramp stepping
    always_ff @(posedge dac_clk) begin
        if (reset) begin
            cur_bit  <= 1'b0;
            ramp_p0  <= '0;
            edge_cnt <= '0;
            div_cnt  <= '0;
            err      <= '0;
        end else if (samp) begin
            cur_bit  <= bus.prbs_bit_out;
            neg      <= diff_new[DATA_W];
            quo      <= mag_new;
            rem      <= '0;
            n_len    <= n_new;
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else if (state == CALC) begin
            {rem, quo} <= div_nxt;
            div_cnt    <= div_cnt + 1'b1;
            if (div_cnt == DIV_LAST) begin
                edge_cnt <= n_len;
                err      <= '0;
            end
        end else if (state == RAMP) begin
            ramp_p0  <= ramp_step(ramp_p0, step, neg);
            err      <= big ? (esum - {1'b0, n_len}) : esum;
            edge_cnt <= edge_cnt - 1'b1;
        end
    end

    // Stage p1: one-pole smoothing of the ramp
    always_ff @(posedge dac_clk) begin
        if (reset) filt_p1 <= '0;
        else       filt_p1 <= iir_step(filt_p1, ramp_p0, clamp_shift(bus.filter_strength));
    end

    assign bus.shaped_prbs_data = filt_p1;
    assign bus.edge_state_dbg   = state;
    assign bus.edge_counter_dbg = edge_cnt;
    assign bus.edge_done        = done_q;
endmodule
